// File: rtl/mc_pwm_pkg.sv
// Shared constants and elaboration helpers for the multi-channel servo pulse generator.
// Direction codes match the two low bits of a channel command word.
package mc_pwm_pkg;

    localparam logic [1:0] DIR_FWD = 2'd0;
    localparam logic [1:0] DIR_NEU = 2'd1;
    localparam logic [1:0] DIR_REV = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Index/counter widths never collapse to zero bits.
    function automatic int clog2_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int us_to_ticks(input int us, input int tpu);
        return us * tpu;
    endfunction

endpackage

// File: rtl/mc_pwm_channel.sv
// One servo output channel: command shadow, frame-boundary latch with the
// accumulator power spreading and reversal interlock, and the pulse comparator.
module mc_pwm_channel
    import mc_pwm_pkg::*;
#(
    parameter int LEVEL_BITS  = 3,
    parameter int DEAD_FRAMES = 2,
    parameter int CNT_W       = 8,
    parameter int W_FWD       = 10,
    parameter int W_NEU       = 15,
    parameter int W_REV       = 20
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  we,
    input  logic [LEVEL_BITS+1:0] cmd_data,
    input  logic                  latch,
    input  logic [CNT_W-1:0]      frame_cnt,
    output logic                  pwm,
    output logic                  drive
);

    localparam int DC_W = clog2_min1(DEAD_FRAMES + 1);
    localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'((DEAD_FRAMES > 0) ? DEAD_FRAMES - 1 : 0);

    logic [LEVEL_BITS+1:0] shadow_reg;
    logic [LEVEL_BITS-1:0] acc_reg, acc_next;
    logic [1:0]            last_dir_reg, last_dir_next;
    logic [DC_W-1:0]       dead_cnt_reg, dead_cnt_next;
    logic [CNT_W-1:0]      width_reg, width_next;
    logic                  drive_reg, drive_next;
    logic                  pwm_reg;

    logic [1:0]            dir;
    logic [LEVEL_BITS-1:0] level;
    logic                  dir_drv, last_drv;
    logic [LEVEL_BITS:0]   sum;

    always_comb begin
        dir           = shadow_reg[1:0];
        level         = shadow_reg[LEVEL_BITS+1:2];
        dir_drv       = (dir == DIR_FWD) || (dir == DIR_REV);
        last_drv      = (last_dir_reg == DIR_FWD) || (last_dir_reg == DIR_REV);
        sum           = {1'b0, acc_reg} + {1'b0, level} + (LEVEL_BITS+1)'(1);
        acc_next      = acc_reg;
        last_dir_next = last_dir_reg;
        dead_cnt_next = dead_cnt_reg;
        width_next    = width_reg;
        drive_next    = drive_reg;
        if (latch) begin
            width_next = CNT_W'(W_NEU);
            drive_next = 1'b0;
            if (dead_cnt_reg != '0) begin
                dead_cnt_next = dead_cnt_reg - DC_W'(1);
                if (dead_cnt_reg == DC_W'(1)) begin
                    last_dir_next = DIR_NEU;
                end
                acc_next = '0;
            end else if ((DEAD_FRAMES > 0) && dir_drv && last_drv && (dir != last_dir_reg)) begin
                dead_cnt_next = DEAD_LOAD;
                if (DEAD_FRAMES == 1) begin
                    last_dir_next = DIR_NEU;
                end
                acc_next = '0;
            end else if (dir_drv) begin
                // Carry out of the accumulator marks a drive frame; the low bits are the remainder.
                drive_next    = sum[LEVEL_BITS];
                acc_next      = sum[LEVEL_BITS-1:0];
                last_dir_next = dir;
                if (sum[LEVEL_BITS]) begin
                    width_next = (dir == DIR_FWD) ? CNT_W'(W_FWD) : CNT_W'(W_REV);
                end
            end else begin
                acc_next = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_reg   <= {{LEVEL_BITS{1'b1}}, DIR_NEU};
            acc_reg      <= '0;
            last_dir_reg <= DIR_NEU;
            dead_cnt_reg <= '0;
            width_reg    <= CNT_W'(W_NEU);
            drive_reg    <= 1'b0;
            pwm_reg      <= 1'b0;
        end else begin
            if (we) begin
                shadow_reg <= cmd_data;
            end
            acc_reg      <= acc_next;
            last_dir_reg <= last_dir_next;
            dead_cnt_reg <= dead_cnt_next;
            width_reg    <= width_next;
            drive_reg    <= drive_next;
            pwm_reg      <= (frame_cnt < width_reg);
        end
    end

    assign pwm   = pwm_reg;
    assign drive = drive_reg;

endmodule

// File: rtl/mc_servo_pwm_gen.sv
// Multi-channel servo pulse generator: shared frame counter and command decode
// feeding one mc_pwm_channel per output pin.
module mc_servo_pwm_gen
    import mc_pwm_pkg::*;
#(
    parameter int CLK_RATE    = 100000000,
    parameter int NUM_CH      = 2,
    parameter int LEVEL_BITS  = 3,
    parameter int FRAME_US    = 20000,
    parameter int FWD_US      = 1000,
    parameter int NEU_US      = 1500,
    parameter int REV_US      = 2000,
    parameter int DEAD_FRAMES = 2
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            CMD_WE,
    input  logic [clog2_min1(NUM_CH)-1:0]   CMD_CH,
    input  logic [LEVEL_BITS+1:0]           CMD_DATA,
    output logic [NUM_CH-1:0]               PWM_OUT,
    output logic                            FRAME_TICK,
    output logic [NUM_CH-1:0]               DRIVE
);

    localparam int TPU     = CLK_RATE / 1000000;
    localparam int FRAME_T = us_to_ticks(FRAME_US, TPU);
    localparam int W_FWD   = us_to_ticks(FWD_US, TPU);
    localparam int W_NEU   = us_to_ticks(NEU_US, TPU);
    localparam int W_REV   = us_to_ticks(REV_US, TPU);
    localparam int CNT_W   = clog2_min1(FRAME_T);
    localparam int CH_W    = clog2_min1(NUM_CH);

    if (TPU == 0 || W_REV >= FRAME_T || NUM_CH < 1 || NUM_CH > 16) begin : g_bad_cfg
        $error("mc_servo_pwm_gen: unsupported timing or channel configuration");
    end

    logic [CNT_W-1:0]  frame_cnt_reg;
    logic              frame_tick;
    logic [NUM_CH-1:0] ch_we;

    assign frame_tick = (frame_cnt_reg == CNT_W'(FRAME_T - 1));
    assign FRAME_TICK = frame_tick;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt_reg <= '0;
        end else if (frame_tick) begin
            frame_cnt_reg <= '0;
        end else begin
            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
        end
    end

    // Out-of-range channel indices match no decode term and are dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_we[gi] = CMD_WE && (CMD_CH == CH_W'(gi));

        mc_pwm_channel #(
            .LEVEL_BITS  (LEVEL_BITS),
            .DEAD_FRAMES (DEAD_FRAMES),
            .CNT_W       (CNT_W),
            .W_FWD       (W_FWD),
            .W_NEU       (W_NEU),
            .W_REV       (W_REV)
        ) u_ch (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .we        (ch_we[gi]),
            .cmd_data  (CMD_DATA),
            .latch     (frame_tick),
            .frame_cnt (frame_cnt_reg),
            .pwm       (PWM_OUT[gi]),
            .drive     (DRIVE[gi])
        );
    end

endmodule

// File: tb/tb_mc_servo_pwm_gen.sv
// Scoreboard bench: two generator instances (interlocked 2-channel, no-interlock
// 3-channel) driven by shared commands and checked frame by frame against a reference model.
module tb_mc_servo_pwm_gen;

    localparam int FT = 100;
    localparam int WF = 10;
    localparam int WN = 15;
    localparam int WR = 20;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       cmd_we;
    logic [1:0] cmd_ch;
    logic [4:0] cmd_data;
    logic       cmd_we_a;
    logic [1:0] pwm_a, drv_a;
    logic [2:0] pwm_b, drv_b;
    logic       tick_a, tick_b;
    bit         mon_en = 1'b0;

    always #5 CLK = ~CLK;

    assign cmd_we_a = cmd_we && (cmd_ch < 2'd2);

    mc_servo_pwm_gen #(
        .CLK_RATE(1000000), .NUM_CH(2), .LEVEL_BITS(3), .FRAME_US(100),
        .FWD_US(10), .NEU_US(15), .REV_US(20), .DEAD_FRAMES(2)
    ) dut_a (
        .CLK(CLK), .RST_N(RST_N), .CMD_WE(cmd_we_a), .CMD_CH(cmd_ch[0]),
        .CMD_DATA(cmd_data), .PWM_OUT(pwm_a), .FRAME_TICK(tick_a), .DRIVE(drv_a)
    );

    mc_servo_pwm_gen #(
        .CLK_RATE(1000000), .NUM_CH(3), .LEVEL_BITS(3), .FRAME_US(100),
        .FWD_US(10), .NEU_US(15), .REV_US(20), .DEAD_FRAMES(0)
    ) dut_b (
        .CLK(CLK), .RST_N(RST_N), .CMD_WE(cmd_we), .CMD_CH(cmd_ch),
        .CMD_DATA(cmd_data), .PWM_OUT(pwm_b), .FRAME_TICK(tick_b), .DRIVE(drv_b)
    );

    typedef struct packed {
        logic [5:0][5:0] w;
        logic [5:0]      drv;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int NCH[2]   = '{2, 3};
    int DEADF[2] = '{2, 0};
    int m_lvl[2][3], m_dir[2][3], m_acc[2][3], m_last[2][3], m_dead[2][3];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic get_pwm(input int d, input int c);
        return (d == 0) ? pwm_a[c] : pwm_b[c];
    endfunction

    function automatic logic get_drv(input int d, input int c);
        return (d == 0) ? drv_a[c] : drv_b[c];
    endfunction

    function automatic bit is_motion(input int dir);
        return (dir == 0) || (dir == 2);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                m_lvl[d][c] = 7; m_dir[d][c] = 1; m_acc[d][c] = 0;
                m_last[d][c] = 1; m_dead[d][c] = 0;
            end
        end
    endtask

    task automatic model_write(input int ch, input int lvl, input int dir);
        for (int d = 0; d < 2; d++) begin
            if (ch < NCH[d]) begin
                m_lvl[d][ch] = lvl;
                m_dir[d][ch] = dir;
            end
        end
    endtask

    // Frame-boundary decision for one channel, returns next frame's width and drive flag.
    task automatic model_latch(input int d, input int c, output int w, output bit drv);
        int dir, sum;
        dir = m_dir[d][c];
        w   = WN;
        drv = 1'b0;
        if (m_dead[d][c] != 0) begin
            m_dead[d][c] = m_dead[d][c] - 1;
            if (m_dead[d][c] == 0) m_last[d][c] = 1;
            m_acc[d][c] = 0;
        end else if (is_motion(dir) && is_motion(m_last[d][c]) && dir != m_last[d][c] && DEADF[d] > 0) begin
            m_dead[d][c] = DEADF[d] - 1;
            if (DEADF[d] == 1) m_last[d][c] = 1;
            m_acc[d][c] = 0;
        end else if (is_motion(dir)) begin
            sum = m_acc[d][c] + m_lvl[d][c] + 1;
            drv = (sum >= 8);
            m_acc[d][c] = drv ? sum - 8 : sum;
            m_last[d][c] = dir;
            if (drv) w = (dir == 0) ? WF : WR;
        end else begin
            m_acc[d][c] = 0;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        int   w;
        bit   drv;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH[d]; c++) begin
                model_latch(d, c, w, drv);
                e.w[d*3+c]   = 6'(w);
                e.drv[d*3+c] = drv;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic push_neutral();
        exp_t e;
        e = '0;
        for (int i = 0; i < 6; i++) e.w[i] = 6'(WN);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        cmd_we = 1'b0;
        RST_N  = 1'b0;
        #1;
        check("reset pwm_a", int'(pwm_a), 0);
        check("reset pwm_b", int'(pwm_b), 0);
        check("reset drive_a", int'(drv_a), 0);
        check("reset drive_b", int'(drv_b), 0);
        check("reset tick", int'({tick_a, tick_b}), 0);
        repeat (3) @(posedge CLK);
        model_reset();
        exp_q.delete();
        push_neutral();
        @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        mon_en = 1'b1;
        $display("reset released");
    endtask

    // One frame of stimulus; optional single write at wpos, optional reset at rst_pos.
    task automatic run_frame(input bit wr, input int wpos, input int ch, input int lvl,
                             input int dir, input int rst_pos);
        logic [2:0] lv;
        logic [1:0] dr;
        for (int pos = 0; pos < FT; pos++) begin
            @(negedge CLK);
            #2;
            cmd_we = 1'b0;
            if (pos == rst_pos) begin
                check("pwm_a0 high before reset", int'(pwm_a[0]), 1);
                do_reset();
                return;
            end
            if (pos == FT - 1) push_expect();
            if (wr && pos == wpos) begin
                lv       = 3'(lvl);
                dr       = 2'(dir);
                cmd_we   = 1'b1;
                cmd_ch   = 2'(ch);
                cmd_data = {lv, dr};
                model_write(ch, lvl, dir);
                $display("write ch=%0d level=%0d dir=%0d at pos %0d", ch, lvl, dir, pos);
            end
        end
    endtask

    // Monitor: pops one expectation per frame and checks the observed pins against it.
    initial begin : monitor
        int   mpos;
        bit   have;
        exp_t cur;
        int   hi_cnt[2][3], shape_bad[2][3], drv_bad[2][3], tick_bad[2];
        int   w;
        logic p, t;
        mpos = 0;
        have = 1'b0;
        cur  = '0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                mpos = 0;
            end else begin
                if (mpos == 0) begin
                    if (exp_q.size() == 0) begin
                        have = 1'b0;
                        check("expectation available", 0, 1);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                    for (int d = 0; d < 2; d++) begin
                        tick_bad[d] = 0;
                        for (int c = 0; c < 3; c++) begin
                            hi_cnt[d][c] = 0; shape_bad[d][c] = 0; drv_bad[d][c] = 0;
                        end
                    end
                end
                for (int d = 0; d < 2; d++) begin
                    t = (d == 0) ? tick_a : tick_b;
                    if (t !== (mpos == FT - 1)) tick_bad[d]++;
                    for (int c = 0; c < NCH[d]; c++) begin
                        w = int'(cur.w[d*3+c]);
                        p = get_pwm(d, c);
                        if (p === 1'b1) hi_cnt[d][c]++;
                        if (p !== (mpos >= 1 && mpos <= w)) shape_bad[d][c]++;
                        if (get_drv(d, c) !== cur.drv[d*3+c]) drv_bad[d][c]++;
                    end
                end
                if (mpos == FT - 1 && have) begin
                    for (int d = 0; d < 2; d++) begin
                        check($sformatf("tick d%0d", d), tick_bad[d], 0);
                        for (int c = 0; c < NCH[d]; c++) begin
                            check($sformatf("width d%0d ch%0d", d, c), hi_cnt[d][c], int'(cur.w[d*3+c]));
                            check($sformatf("shape d%0d ch%0d", d, c), shape_bad[d][c], 0);
                            check($sformatf("drive d%0d ch%0d (want %0b)", d, c, cur.drv[d*3+c]), drv_bad[d][c], 0);
                        end
                    end
                    $display("frame checked: a=%0d/%0d b=%0d/%0d/%0d drv_a=%b drv_b=%b",
                             hi_cnt[0][0], hi_cnt[0][1], hi_cnt[1][0], hi_cnt[1][1], hi_cnt[1][2],
                             drv_a, drv_b);
                end
                mpos = (mpos == FT - 1) ? 0 : mpos + 1;
            end
        end
    end

    initial begin : stimulus
        int wr, wpos, ch, lvl, dir;
        RST_N    = 1'b1;
        cmd_we   = 1'b0;
        cmd_ch   = 2'd0;
        cmd_data = 5'd0;
        #3;
        do_reset();
        repeat (3) run_frame(0, 0, 0, 0, 0, -1);
        // full power forward on ch0
        run_frame(1, 30, 0, 7, 0, -1);
        repeat (3) run_frame(0, 0, 0, 0, 0, -1);
        // half power reverse (swap from forward)
        run_frame(1, 40, 0, 3, 2, -1);
        repeat (10) run_frame(0, 0, 0, 0, 0, -1);
        // minimum power reverse
        run_frame(1, 50, 0, 0, 2, -1);
        repeat (9) run_frame(0, 0, 0, 0, 0, -1);
        // full forward then a direct swap to full reverse
        run_frame(1, 20, 0, 7, 0, -1);
        run_frame(1, 20, 1, 7, 0, -1);
        run_frame(1, 60, 0, 7, 2, -1);
        repeat (4) run_frame(0, 0, 0, 0, 0, -1);
        // write in the tick cycle
        run_frame(1, FT - 1, 1, 7, 2, -1);
        repeat (3) run_frame(0, 0, 0, 0, 0, -1);
        // channel 2 (only dut_b), channel 3 (nobody), neutral dir code 3
        run_frame(1, 10, 2, 7, 0, -1);
        run_frame(1, 10, 3, 7, 2, -1);
        run_frame(1, 10, 0, 7, 3, -1);
        repeat (2) run_frame(0, 0, 0, 0, 0, -1);
        for (int k = 0; k < 30; k++) begin
            wr   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            wpos = ($urandom_range(0, 4) == 0) ? FT - 1 : int'($urandom_range(0, FT - 2));
            ch   = $urandom_range(0, 3);
            lvl  = $urandom_range(0, 7);
            dir  = $urandom_range(0, 3);
            run_frame(wr[0], wpos, ch, lvl, dir, -1);
        end
        // reach a steady reverse drive, then reset mid-pulse
        run_frame(1, 10, 0, 7, 2, -1);
        repeat (3) run_frame(0, 0, 0, 0, 0, -1);
        run_frame(0, 0, 0, 0, 0, 5);
        repeat (3) run_frame(0, 0, 0, 0, 0, -1);
        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_servo_pwm_gen.md
Name: mc_servo_pwm_gen

Overview:
- Parametrised multi-channel generator for motor-controller servo-style pulses.
- Produces the actual PWM pin waveform: fixed frame period, pulse width chosen by direction (forward, neutral or reverse).
- Power level is realised by spreading drive frames evenly over a 2^LEVEL_BITS-frame superframe (accumulator method); all other frames carry neutral pulses.
- Sits between navigation/arm command logic and the motor-controller output pins. Adds three things the earlier table-based modulator lacked: frame-boundary command latching, a reversal interlock, and a configurable channel count and resolution.

Parameters:
- CLK_RATE, 100000000, input clock in Hz.
- NUM_CH, 2, number of independent output channels (1..16).
- LEVEL_BITS, 3, power-level width; level L gives (L+1)/2^LEVEL_BITS duty.
- FRAME_US, 20000, frame period in microseconds.
- FWD_US, 1000, forward pulse width in microseconds.
- NEU_US, 1500, neutral pulse width in microseconds.
- REV_US, 2000, reverse pulse width in microseconds.
- DEAD_FRAMES, 2, neutral frames forced on a direct forward/reverse swap; 0 disables the interlock.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CMD_WE  in  1  command write strobe, one cycle.
- CMD_CH  in  clog2(NUM_CH) (min 1)  target channel index.
- CMD_DATA  in  LEVEL_BITS+2  {level[LEVEL_BITS-1:0], dir[1:0]}; dir codes: 0 = FWD, 1 = NEU, 2 = REV, 3 = NEU.
- PWM_OUT  out  NUM_CH  servo pulse per channel.
- FRAME_TICK  out  1  one-cycle strobe in the last cycle of each frame.
- DRIVE  out  NUM_CH  high for the whole frame when the channel is emitting a FWD/REV pulse.

Behaviour:
- Tick conversion:
  - TPU = CLK_RATE/1000000.
  - FRAME_T = FRAME_US*TPU; width ticks W_x = x_US*TPU.
  - Elaboration fails if W_REV >= FRAME_T or TPU == 0.
- Frame counter: one shared counter, 0..FRAME_T-1, wraps to 0. FRAME_TICK = 1 when the counter equals FRAME_T-1.
- Shadow registers, one per channel:
  - On CMD_WE with CMD_CH < NUM_CH, shadow[CMD_CH] <= CMD_DATA.
  - CMD_CH >= NUM_CH is ignored.
- Latch: at the edge ending a FRAME_TICK cycle, each channel evaluates its shadow as it stood before that edge. A CMD_WE in the FRAME_TICK cycle takes effect one frame later.
- Per-channel latch decision, evaluated in this priority order:
  1. dead_cnt != 0: frame is neutral; dead_cnt--; if it reaches 0, last_dir <= NEU; acc <= 0.
  2. dir ∈ {FWD, REV}, last_dir ∈ {FWD, REV}, dir != last_dir, DEAD_FRAMES > 0: frame is neutral; dead_cnt <= DEAD_FRAMES-1; if DEAD_FRAMES == 1, last_dir <= NEU; acc <= 0.
  3. dir ∈ {FWD, REV}:
     - sum = acc + level + 1, computed LEVEL_BITS+1 wide.
     - drive = (sum >= 2^LEVEL_BITS).
     - acc <= drive ? sum - 2^LEVEL_BITS : sum.
     - last_dir <= dir.
     - The frame uses dir if drive, otherwise neutral.
  4. Neutral command: frame is neutral; acc <= 0; last_dir unchanged.
- Output:
  - PWM_OUT[i] <= (frame_cnt < width_i), registered. Each frame has exactly width_i high cycles, delayed one cycle from the counter.
  - DRIVE[i] is registered at the latch edge.
  - Every frame carries a pulse, including neutral frames; the line is never silent.
- Reset (asynchronous), all of the following:
  - frame_cnt = 0, PWM_OUT = 0, FRAME_TICK = 0, DRIVE = 0.
  - shadow = {level max, NEU}; active width = W_NEU.
  - acc = 0, last_dir = NEU, dead_cnt = 0.
  - Reset asserted mid-pulse drops PWM_OUT within the same cycle. After release, frame 0 is a neutral frame.
- Level max (all ones): drives every frame. Level 0: drives 1 frame in 2^LEVEL_BITS.

Decomposition:
- Package mc_pwm_pkg:
  - dir code localparams (DIR_FWD, DIR_NEU, DIR_REV).
  - us_to_ticks function.
  - clog2 helper.
- Sub-module mc_pwm_channel:
  - contains shadow, acc, last_dir, dead_cnt, width register and comparator.
  - instantiated NUM_CH times by a generate loop.
  - the top keeps the frame counter, FRAME_TICK and write decode.

Test Plan (bench parameters CLK_RATE=1000000, FRAME_US=100, FWD_US=10, NEU_US=15, REV_US=20, LEVEL_BITS=3, NUM_CH=2):
- Reset release, no commands -> both PWM_OUT show 15-cycle pulses every 100 cycles; DRIVE = 0; FRAME_TICK at counts 99, 199, ...
- Write ch0 {level 7, FWD} -> from the next frame, 10-cycle pulses every frame; DRIVE[0] = 1 continuously; ch1 unchanged.
- Write ch0 {level 3, REV} -> over 8 frames, exactly 4 frames have 20-cycle pulses, alternating with 15-cycle frames. Level 0 -> 1 in 8 frames.
- ch0 at {7, FWD}, then write {7, REV} -> 2 neutral frames (15-cycle pulses), then continuous 20-cycle pulses. With DEAD_FRAMES=0 -> immediate swap.
- CMD_WE in the FRAME_TICK cycle -> the following frame still uses the old width; the change appears one frame later. CMD_CH = 2 -> no channel changes. dir code 3 -> neutral.
- RST_N asserted at count 5 of a 20-cycle pulse -> PWM_OUT = 0 immediately. After release, the first frame is neutral and DRIVE = 0.
